// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the single-precision mul/div sequencer.
// Flag vector order is {invalid, divzero, overflow, underflow, inexact}.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_EXEC,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // Mantissa with hidden bit; denormals flush to zero.
  function automatic logic [23:0] mant_of(logic [31:0] x);
    return (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
  endfunction

endpackage

// File: rtl/fp_muldiv_sequencer_classify.sv
// Operand classifier: zero (denormals count as zero), inf, NaN, sNaN.
// Purely combinational, one instance per operand.
module fp_classify
  import fp_seq_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);

  logic [7:0]  e;
  logic [22:0] f;

  assign e = x[30:23];
  assign f = x[22:0];

  assign is_zero = (e == 8'd0);
  assign is_inf  = (e == EXP_INF) && (f == 23'd0);
  assign is_nan  = (e == EXP_INF) && (f != 23'd0);
  assign is_snan = is_nan && !f[22];

endmodule

// File: rtl/fp_muldiv_sequencer.sv
// Single-issue sequencer for the shared fp32 mul/div mantissa datapath.
// Optional FP_SPECIAL_BYPASS_EN: resolve special operands in CLASSIFY.
module fp_muldiv_sequencer
  import fp_seq_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags,
  output logic        mul_start,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic [47:0] mul_result,
  output logic        div_start,
  output logic [23:0] div_a,
  output logic [23:0] div_b,
  input  logic        div_done,
  input  logic [26:0] div_quotient,
  output logic        norm_is_div,
  output logic [7:0]  norm_exp_in,
  input  logic [26:0] norm_mant,
  input  logic [7:0]  norm_exp,
  input  logic        norm_uf,
  input  logic        norm_of
);

`ifdef FP_SPECIAL_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);
  localparam logic signed [9:0] BIAS10 = 10'(BIAS);

  state_t state_q, state_d;

  logic          op_q;
  logic [31:0]   a_q, b_q;
  logic          sign_q;
  logic [7:0]    exp_q;
  logic [CW-1:0] cnt_q;
  logic          spec_q;
  logic [31:0]   spec_res_q;
  logic [4:0]    spec_flg_q;
  logic [26:0]   nm_q;
  logic [7:0]    ne_q;
  logic          nuf_q, nof_q;
  logic [31:0]   res_q;
  logic [4:0]    flg_q;

  // The normalizer consumes the raw mantissa result directly.
  logic unused_raw;
  assign unused_raw = ^{mul_result, div_quotient, norm_exp[0]};

  logic za, ia, na, sna;
  logic zb, ib, nb, snb;

  fp_classify u_cls_a (
    .x       (a_q),
    .is_zero (za),
    .is_inf  (ia),
    .is_nan  (na),
    .is_snan (sna)
  );

  fp_classify u_cls_b (
    .x       (b_q),
    .is_zero (zb),
    .is_inf  (ib),
    .is_nan  (nb),
    .is_snan (snb)
  );

  logic sgn;
  assign sgn = a_q[31] ^ b_q[31];

  logic signed [9:0] ei;
  logic signed [9:0] ea, eb;
  logic              exp_uf, exp_of;

  assign ea = $signed({2'b00, a_q[30:23]});
  assign eb = $signed({2'b00, b_q[30:23]});
  assign ei = (op_q == OP_DIV) ? (ea - eb + BIAS10)
                               : (ea + eb - BIAS10);
  assign exp_uf = (ei < 10'sd1);
  assign exp_of = (ei > 10'sd254);

  logic [31:0] inf_w, zero_w;
  assign inf_w  = {sgn, EXP_INF, 23'd0};
  assign zero_w = {sgn, 31'd0};

  logic        sp_hit;
  logic [31:0] sp_res;
  logic [4:0]  sp_flg;

  // Special-operand result; NaN inputs take priority over everything.
  always_comb begin
    sp_hit = na | nb | za | zb | ia | ib;
    sp_res = zero_w;
    sp_flg = '0;
    if (na || nb) begin
      sp_res = QNAN;
      sp_flg[FLG_INVALID] = sna | snb;
    end else if (op_q == OP_MUL) begin
      if ((za && ib) || (ia && zb)) begin
        sp_res = QNAN;
        sp_flg[FLG_INVALID] = 1'b1;
      end else if (ia || ib) begin
        sp_res = inf_w;
      end
    end else begin
      if ((za && zb) || (ia && ib)) begin
        sp_res = QNAN;
        sp_flg[FLG_INVALID] = 1'b1;
      end else if (zb && !ia) begin
        sp_res = inf_w;
        sp_flg[FLG_DIVZERO] = 1'b1;
      end else if (ia) begin
        sp_res = inf_w;
      end
    end
  end

  logic        cls_exit;
  logic [31:0] cls_res;
  logic [4:0]  cls_flg;

  assign cls_exit = sp_hit ? BYPASS : (exp_uf | exp_of);

  // Result for the CLASSIFY early exit.
  always_comb begin
    cls_res = zero_w;
    cls_flg = '0;
    if (sp_hit) begin
      cls_res = sp_res;
      cls_flg = sp_flg;
    end else if (exp_of) begin
      cls_res = inf_w;
      cls_flg[FLG_OVERFLOW] = 1'b1;
      cls_flg[FLG_INEXACT]  = 1'b1;
    end else begin
      cls_flg[FLG_UNDERFLOW] = 1'b1;
      cls_flg[FLG_INEXACT]   = 1'b1;
    end
  end

  logic [23:0] rm;
  logic        rup;
  logic [24:0] rsum;
  logic [23:0] rmant;
  logic [8:0]  rexp;

  assign rm    = nm_q[26:3];
  assign rup   = nm_q[2] & (nm_q[1] | nm_q[0] | rm[0]);
  assign rsum  = {1'b0, rm} + 25'(rup);
  assign rmant = rsum[24] ? rsum[24:1] : rsum[23:0];
  assign rexp  = {1'b0, ne_q} + 9'(rsum[24]);

  logic [31:0] rnd_res;
  logic [4:0]  rnd_flg;

  // Round to nearest even, then clamp or substitute the special result.
  always_comb begin
    rnd_res = {sign_q, rexp[7:0], rmant[22:0]};
    rnd_flg = '0;
    rnd_flg[FLG_INEXACT] = |nm_q[2:0];
    if (nof_q || (rexp >= 9'd255)) begin
      rnd_res = {sign_q, EXP_INF, 23'd0};
      rnd_flg[FLG_OVERFLOW] = 1'b1;
      rnd_flg[FLG_INEXACT]  = 1'b1;
    end else if (nuf_q || (rexp == 9'd0)) begin
      rnd_res = {sign_q, 31'd0};
      rnd_flg[FLG_UNDERFLOW] = 1'b1;
      rnd_flg[FLG_INEXACT]   = 1'b1;
    end
    if (spec_q) begin
      rnd_res = spec_res_q;
      rnd_flg = spec_flg_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/start outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        state_d = cls_exit ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          mul_start = (cnt_q == '0);
          if (cnt_q == CNT_LAST) state_d = S_NORM;
        end else begin
          div_start = (cnt_q == '0);
          if (div_done) state_d = S_NORM;
        end
      end
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, estimate, normalizer capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      nm_q       <= '0;
      ne_q       <= '0;
      nuf_q      <= 1'b0;
      nof_q      <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
          end
        end
        S_CLASSIFY: begin
          sign_q     <= sgn;
          exp_q      <= ei[7:0];
          cnt_q      <= '0;
          spec_q     <= sp_hit;
          spec_res_q <= sp_res;
          spec_flg_q <= sp_flg;
          if (cls_exit) begin
            res_q <= cls_res;
            flg_q <= cls_flg;
          end
        end
        S_EXEC: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        S_NORM: begin
          nm_q  <= norm_mant;
          ne_q  <= norm_exp;
          nuf_q <= norm_uf;
          nof_q <= norm_of;
        end
        S_ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flg;
        end
        default: ;
      endcase
    end
  end

  assign out_result  = res_q;
  assign out_flags   = flg_q;
  assign mul_a       = mant_of(a_q);
  assign mul_b       = mant_of(b_q);
  assign div_a       = mant_of(a_q);
  assign div_b       = mant_of(b_q);
  assign norm_is_div = op_q;
  assign norm_exp_in = exp_q;

endmodule

// File: tb/tb_fp_muldiv_sequencer.sv
// Directed self-checking bench for fp_muldiv_sequencer.
// Includes multiplier and normalizer models; divider done is driven inline.
module tb_fp_muldiv_sequencer;

`ifdef FP_SPECIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        mul_start;
  logic [23:0] mul_a, mul_b;
  logic [47:0] mul_result;
  logic        div_start;
  logic [23:0] div_a, div_b;
  logic        div_done;
  logic [26:0] div_quotient;
  logic        norm_is_div;
  logic [7:0]  norm_exp_in;
  logic [26:0] norm_mant;
  logic [7:0]  norm_exp;
  logic        norm_uf, norm_of;

  int errors = 0;
  int checks = 0;

  fp_muldiv_sequencer #(.MUL_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .norm_is_div  (norm_is_div),
    .norm_exp_in  (norm_exp_in),
    .norm_mant    (norm_mant),
    .norm_exp     (norm_exp),
    .norm_uf      (norm_uf),
    .norm_of      (norm_of)
  );

  always #5 clk = ~clk;

  assign mul_result = 48'(mul_a) * 48'(mul_b);

  int nexp;

  // Normalizer model: 1.F plus guard/round/sticky.
  always_comb begin
    nexp = int'(norm_exp_in);
    norm_mant = '0;
    if (!norm_is_div) begin
      if (mul_result[47]) begin
        norm_mant = {mul_result[47:24], mul_result[23],
                     mul_result[22], |mul_result[21:0]};
        nexp = nexp + 1;
      end else begin
        norm_mant = {mul_result[46:23], mul_result[22],
                     mul_result[21], |mul_result[20:0]};
      end
    end else begin
      if (div_quotient[26]) begin
        norm_mant = div_quotient;
      end else begin
        norm_mant = {div_quotient[25:0], 1'b0};
        nexp = nexp - 1;
      end
    end
    norm_uf  = (nexp <= 0);
    norm_of  = (nexp >= 255);
    norm_exp = 8'(nexp);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at #1 after an edge; lat = edges after accept to out_valid.
  task automatic run_op(input logic op, input logic [31:0] a,
                        input logic [31:0] b, input int dly,
                        input bit spur, output int lat,
                        output bit saw, output int nms);
    int sl;
    sl = 0;
    saw = 1'b0;
    nms = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      if (mul_start) nms++;
      if (div_start && !saw) begin
        saw = 1'b1;
        sl = lat;
      end
      div_done = spur | (saw && (lat == sl + dly));
      @(posedge clk); #1;
      lat++;
    end
    div_done = 1'b0;
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic op_check(input string tag, input logic op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int dly, input int exp_lat,
                          input logic [31:0] exp_res,
                          input logic [4:0] exp_flg);
    int lat;
    bit saw;
    int nms;
    run_op(op, a, b, dly, 1'b0, lat, saw, nms);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_flg"}, 32'(out_flags), 32'(exp_flg));
    finish_out(tag);
  endtask

  int  lat;
  bit  saw;
  int  nms;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    div_done = 1'b0;
    div_quotient = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    div_done = 1'b1;
    @(posedge clk); #1;
    div_done = 1'b0;
    @(posedge clk); #1;
    chk("spur_idle_in_ready", 32'(in_ready), 32'd1);
    chk("spur_idle_out_valid", 32'(out_valid), 32'd0);

    // 2 x 3 with div_done held high the whole time.
    run_op(1'b0, 32'h4000_0000, 32'h4040_0000, 0, 1'b1,
           lat, saw, nms);
    chk("mul23_lat", 32'(lat), 32'd5);
    chk("mul23_nstart", 32'(nms), 32'd1);
    chk("mul23_divstart", 32'(saw), 32'd0);
    chk("mul23_res", out_result, 32'h40C0_0000);
    chk("mul23_flg", 32'(out_flags), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_res", out_result, 32'h40C0_0000);
      chk("hold_flg", 32'(out_flags), 32'd0);
    end
    finish_out("mul23");

    div_quotient = 27'h600_0000;
    run_op(1'b1, 32'h4040_0000, 32'h4000_0000, 27, 1'b0,
           lat, saw, nms);
    chk("div32_lat", 32'(lat), 32'd31);
    chk("div32_start", 32'(saw), 32'd1);
    chk("div32_res", out_result, 32'h3FC0_0000);
    chk("div32_flg", 32'(out_flags), 32'd0);
    finish_out("div32");

    run_op(1'b1, 32'h3F80_0000, 32'h0000_0000, 3, 1'b0,
           lat, saw, nms);
    chk("div10_lat", 32'(lat), BYP ? 32'd1 : 32'd7);
    chk("div10_start", 32'(saw), BYP ? 32'd0 : 32'd1);
    chk("div10_res", out_result, 32'h7F80_0000);
    chk("div10_flg", 32'(out_flags), 32'h08);
    finish_out("div10");

    run_op(1'b0, 32'h0000_0000, 32'h7F80_0000, 0, 1'b0,
           lat, saw, nms);
    chk("mul0inf_lat", 32'(lat), BYP ? 32'd1 : 32'd5);
    chk("mul0inf_nstart", 32'(nms), BYP ? 32'd0 : 32'd1);
    chk("mul0inf_res", out_result, 32'h7FC0_0000);
    chk("mul0inf_flg", 32'(out_flags), 32'h10);
    finish_out("mul0inf");

    op_check("mul_of", 1'b0, 32'h7F00_0000, 32'h7F00_0000, 0, 1,
             32'h7F80_0000, 5'b00101);
    op_check("mul_uf", 1'b0, 32'h0080_0000, 32'h0080_0000, 0, 1,
             32'h0000_0000, 5'b00011);
    op_check("mul_snan", 1'b0, 32'h7FA0_0000, 32'h3F80_0000, 0,
             BYP ? 1 : 5, 32'h7FC0_0000, 5'b10000);
    op_check("mul_qnan", 1'b0, 32'h7FC0_0001, 32'h3F80_0000, 0,
             BYP ? 1 : 5, 32'h7FC0_0000, 5'b00000);
    op_check("mul_neg", 1'b0, 32'hC000_0000, 32'h4040_0000, 0, 5,
             32'hC0C0_0000, 5'b00000);
    op_check("mul_rnd", 1'b0, 32'h3FFF_FFFF, 32'h3F80_0001, 0, 5,
             32'h4000_0000, 5'b00001);

    div_quotient = 27'h7FF_FFFF;
    op_check("div_carry", 1'b1, 32'h3F80_0000, 32'h3F80_0000, 2, 6,
             32'h4000_0000, 5'b00001);
    div_quotient = 27'h400_0004;
    op_check("div_tie_even", 1'b1, 32'h3F80_0000, 32'h3F80_0000, 2,
             6, 32'h3F80_0000, 5'b00001);
    div_quotient = 27'h400_000C;
    op_check("div_tie_up", 1'b1, 32'h3F80_0000, 32'h3F80_0000, 2,
             6, 32'h3F80_0002, 5'b00001);

    // Reset while the divide waits in EXEC, then a late div_done.
    in_valid = 1'b1;
    in_op = 1'b1;
    in_a = 32'h4040_0000;
    in_b = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstx_div_start", 32'(div_start), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstx_out_valid", 32'(out_valid), 32'd0);
    chk("rstx_in_ready", 32'(in_ready), 32'd1);
    chk("rstx_div_start0", 32'(div_start), 32'd0);
    chk("rstx_out_result", out_result, 32'd0);
    chk("rstx_out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    div_done = 1'b1;
    @(posedge clk); #1;
    div_done = 1'b0;
    @(posedge clk); #1;
    chk("rstx_late_in_ready", 32'(in_ready), 32'd1);
    chk("rstx_late_out_valid", 32'(out_valid), 32'd0);

    op_check("mul_after_rst", 1'b0, 32'h4000_0000, 32'h4040_0000, 0,
             5, 32'h40C0_0000, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
